// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: control codes, ALU op encodings,
// issue-stage state encoding and a small helper used when capturing flags.
package alu_pkg;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Only the adder ops (ADD, SUB) report a meaningful overflow; SLT reuses the adder but not its flag.
  function automatic logic op_has_overflow(input logic [1:0] op);
    return (op == OP_ADD);
  endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational decode of a 4-bit ALU control code into ALU steering signals,
// flagging every code outside the supported set as illegal.
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [3:0] i_ctl,
  output logic       o_ainvert,
  output logic       o_bnegate,
  output logic [1:0] o_op,
  output logic       o_illegal
);

  // Table decode; anything not listed is illegal and leaves the controls at AND/0.
  always_comb begin
    o_ainvert = 1'b0;
    o_bnegate = 1'b0;
    o_op      = OP_AND;
    o_illegal = 1'b0;
    case (i_ctl)
      CTL_AND: o_op = OP_AND;
      CTL_OR:  o_op = OP_OR;
      CTL_ADD: o_op = OP_ADD;
      CTL_SUB: begin
        o_bnegate = 1'b1;
        o_op      = OP_ADD;
      end
      CTL_SLT: begin
        o_bnegate = 1'b1;
        o_op      = OP_SLT;
      end
      CTL_NOR: begin
        o_ainvert = 1'b1;
        o_bnegate = 1'b1;
        o_op      = OP_AND;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage for an external combinational ALU: accepts one request in IDLE,
// drives registered ALU controls for one EXEC cycle, then holds the result in DONE.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_ctl,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic             alu_ainvert,
  output logic             alu_bnegate,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_illegal
);

  state_e           r_state;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_alu_in1;
  logic [WIDTH-1:0] r_alu_in2;
  logic             r_alu_ainvert;
  logic             r_alu_bnegate;
  logic [1:0]       r_alu_op;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_overflow;
  logic             r_out_zero;
  logic             r_out_illegal;

  logic             w_ainvert;
  logic             w_bnegate;
  logic [1:0]       w_op;
  logic             w_illegal;

  alu_ctl_decode u_decode (
    .i_ctl     (in_ctl),
    .o_ainvert (w_ainvert),
    .o_bnegate (w_bnegate),
    .o_op      (w_op),
    .o_illegal (w_illegal)
  );

  // Issue FSM; ALU controls only change on acceptance so they stay quiet outside EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_in_ready     <= 1'b1;
      r_alu_in1      <= {WIDTH{1'b0}};
      r_alu_in2      <= {WIDTH{1'b0}};
      r_alu_ainvert  <= 1'b0;
      r_alu_bnegate  <= 1'b0;
      r_alu_op       <= 2'b00;
      r_out_valid    <= 1'b0;
      r_out_result   <= {WIDTH{1'b0}};
      r_out_overflow <= 1'b0;
      r_out_zero     <= 1'b0;
      r_out_illegal  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (w_illegal) begin
              r_out_result   <= {WIDTH{1'b0}};
              r_out_overflow <= 1'b0;
              r_out_zero     <= 1'b0;
              r_out_illegal  <= 1'b1;
              r_out_valid    <= 1'b1;
              r_state        <= ST_DONE;
            end else begin
              r_alu_in1     <= in_a;
              r_alu_in2     <= in_b;
              r_alu_ainvert <= w_ainvert;
              r_alu_bnegate <= w_bnegate;
              r_alu_op      <= w_op;
              r_state       <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          r_out_result   <= alu_result;
          r_out_zero     <= alu_zero;
          r_out_overflow <= op_has_overflow(r_alu_op) & alu_overflow;
          r_out_illegal  <= 1'b0;
          r_out_valid    <= 1'b1;
          r_state        <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign alu_in1      = r_alu_in1;
  assign alu_in2      = r_alu_in2;
  assign alu_ainvert  = r_alu_ainvert;
  assign alu_bnegate  = r_alu_bnegate;
  assign alu_op       = r_alu_op;
  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_overflow = r_out_overflow;
  assign out_zero     = r_out_zero;
  assign out_illegal  = r_out_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised bench for alu_issue_stage with an attached ALU model and an
// operation-level reference model for expected results and flags.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_ctl;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        alu_ainvert;
  logic        alu_bnegate;
  logic [1:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_zero;
  logic        out_illegal;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_stage #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_ctl       (in_ctl),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_ainvert  (alu_ainvert),
    .alu_bnegate  (alu_bnegate),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .out_illegal  (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The external ALU: invert/negate stage feeding AND/OR/adder/SLT.
  logic [31:0] alu_a_s;
  logic [31:0] alu_b_s;
  logic [32:0] alu_sum_s;
  always_comb begin
    alu_a_s      = alu_ainvert ? ~alu_in1 : alu_in1;
    alu_b_s      = alu_bnegate ? ~alu_in2 : alu_in2;
    alu_sum_s    = {1'b0, alu_a_s} + {1'b0, alu_b_s} + {32'd0, alu_bnegate};
    alu_overflow = (alu_a_s[31] == alu_b_s[31]) && (alu_sum_s[31] != alu_a_s[31]);
    case (alu_op)
      2'b00:   alu_result = alu_a_s & alu_b_s;
      2'b01:   alu_result = alu_a_s | alu_b_s;
      2'b10:   alu_result = alu_sum_s[31:0];
      default: alu_result = {31'd0, alu_sum_s[31] ^ alu_overflow};
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: operation semantics straight from the control code.
  function automatic void model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov, output logic il,
                                output logic [3:0] ctrl);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    il = 1'b0;
    r  = 32'd0;
    case (ctl)
      4'b0000: begin r = a & b;     ctrl = 4'b0000; end
      4'b0001: begin r = a | b;     ctrl = 4'b0001; end
      4'b0010: begin s = sa + sb; r = a + b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); ctrl = 4'b0010; end
      4'b0110: begin s = sa - sb; r = a - b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); ctrl = 4'b0110; end
      4'b0111: begin r = (sa < sb) ? 32'd1 : 32'd0; ctrl = 4'b0111; end
      4'b1100: begin r = ~(a | b);  ctrl = 4'b1100; end
      default: begin il = 1'b1; ctrl = 4'b0000; end
    endcase
  endfunction

  task automatic run_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        eov, eil;
    logic [3:0]  ectl;
    logic [67:0] prev_alu;
    model(ctl, a, b, er, eov, eil, ectl);
    prev_alu = {alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op};
    chk("in_ready_idle", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_ctl    = ctl;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_busy", in_ready, 1'b0);
    in_valid = 1'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    in_ctl   = 4'($urandom);
    if (eil) begin
      chk("alu_unchanged", {alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op}, prev_alu);
    end else begin
      chk("alu_ops", {alu_in1, alu_in2}, {a, b});
      chk("alu_ctl", {alu_ainvert, alu_bnegate, alu_op}, ectl);
      chk("valid_exec", out_valid, 1'b0);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("valid", out_valid, 1'b1);
    chk("result", out_result, er);
    chk("flags", {out_overflow, out_zero, out_illegal}, {eov, (er == 32'd0) && !eil, eil});
    out_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {out_valid, in_ready}, 2'b10);
      chk("hold_data", {out_result, out_overflow, out_zero, out_illegal}, {er, eov, (er == 32'd0) && !eil, eil});
      if (i == hold - 1) out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("handshake", {out_valid, in_ready}, 2'b01);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] legal [6];
    legal[0] = 4'b0000; legal[1] = 4'b0001; legal[2] = 4'b0010;
    legal[3] = 4'b0110; legal[4] = 4'b0111; legal[5] = 4'b1100;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    in_ctl    = 4'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_state", {out_valid, out_result, out_overflow, out_zero, out_illegal}, 36'd0);
    chk("reset_alu", {alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op}, 68'd0);
    rst_n = 1'b1;

    // First request accepted on the first edge after release.
    run_op(4'b0010, 32'h7FFFFFFF, 32'h00000001, 0);
    run_op(4'b0110, 32'h00000005, 32'h00000005, 1);
    run_op(4'b0111, 32'hFFFFFFFF, 32'h00000001, 0);
    run_op(4'b1100, 32'h00000000, 32'h00000000, 0);
    run_op(4'b1111, 32'h12345678, 32'h9ABCDEF0, 2);
    run_op(4'b0001, 32'hF0F00000, 32'h0000F0F0, 3);
    run_op(4'b0110, 32'h80000000, 32'h00000001, 0);

    // Reset in the middle of EXEC.
    in_valid = 1'b1; in_a = 32'hDEADBEEF; in_b = 32'h00000011; in_ctl = 4'b0010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_exec_out", {out_valid, out_result, out_overflow, out_zero, out_illegal}, 36'd0);
    chk("rst_exec_alu", {alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op}, 68'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_valid_after_rst", {out_valid, in_ready}, 2'b01);
    end
    run_op(4'b0010, 32'h00000003, 32'h00000004, 0);

    for (int k = 0; k < 40; k++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal[$urandom_range(0, 5)];
      run_op(c, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and result.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset: one clock, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream operation request.
REQ-005 in_ready  output  1  stage can accept a request.
REQ-006 in_a, in_b  input  WIDTH each  operands.
REQ-007 in_ctl  input  4  ALU control code.
REQ-008 alu_in1, alu_in2  output  WIDTH each  registered operands to ALU.
REQ-009 alu_ainvert, alu_bnegate  output  1 each  registered ALU controls.
REQ-010 alu_op  output  2  registered ALU op (00 AND, 01 OR, 10 ADD, 11 SLT).
REQ-011 alu_result  input  WIDTH  from ALU (combinational).
REQ-012 alu_overflow, alu_zero  input  1 each  from ALU.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_result  output  WIDTH  captured result.
REQ-016 out_overflow, out_zero, out_illegal  output  1 each  captured flags.

Function
REQ-017 Decode table (ainvert,bnegate,op): 0000 AND (0,0,00); 0001 OR (0,0,01); 0010 ADD (0,0,10); 0110 SUB (0,1,10); 0111 SLT (0,1,11); 1100 NOR (1,1,00); all other codes illegal.
REQ-018 FSM states IDLE, EXEC, DONE; in_ready = 1 only in IDLE.
REQ-019 IDLE: in_valid=1 at edge with legal in_ctl -> register operands and decoded controls onto alu_* outputs, go EXEC.
REQ-020 IDLE: in_valid=1 with illegal in_ctl -> out_result=0, out_overflow=0, out_zero=0, out_illegal=1, go DONE directly; alu_* outputs unchanged.
REQ-021 EXEC lasts exactly one cycle; at its closing edge capture alu_result, alu_zero into out regs, out_illegal=0, go DONE.
REQ-022 out_overflow = alu_overflow for ADD and SUB only; forced 0 for AND, OR, NOR, SLT.
REQ-023 DONE: out_valid=1; out_* held stable until out_valid and out_ready both 1 at an edge, then go IDLE.
REQ-024 Latency: request accepted at edge N -> out_valid high after edge N+2 (N+1 for illegal); minimum request spacing 3 cycles (2 illegal).
REQ-025 in_valid ignored outside IDLE; no request is lost or duplicated; acceptance occurs only when in_valid and in_ready both 1.
REQ-026 alu_* outputs hold last issued values outside EXEC (no glitch-driven toggling).
REQ-027 out_ready asserted before out_valid has no effect; out_valid never drops without handshake.

Reset
REQ-028 rst_n low asynchronously forces state IDLE, in_ready 1 after release, out_valid 0, all alu_* and out_* data/flag outputs 0.
REQ-029 Reset during EXEC or DONE discards the in-flight operation; no out_valid pulse follows release.
REQ-030 First request is accepted at the first rising edge after rst_n deasserts.

Structure
REQ-031 Shared package alu_pkg holds ALU control code constants (AND, OR, ADD, SUB, SLT, NOR), alu_op encodings and FSM state encoding.
REQ-032 Decoder is a separate combinational sub-module alu_ctl_decode (in_ctl -> ainvert, bnegate, op, illegal), reused by other control units.
REQ-033 Block contains no arithmetic; all computation is performed by the external ALU.

Verification
REQ-034 ADD 7FFFFFFF + 00000001, ALU model attached -> out_result 80000000, out_overflow 1, out_zero 0, out_valid at N+2.
REQ-035 SUB 00000005 - 00000005 -> alu_bnegate 1, alu_op 10, out_result 00000000, out_zero 1, out_overflow 0.
REQ-036 SLT FFFFFFFF vs 00000001 -> alu_op 11, out_result 00000001, out_overflow 0; NOR 0 vs 0 -> FFFFFFFF.
REQ-037 out_ready held low 3 cycles in DONE with in_valid high -> out_* stable, in_ready 0, no second acceptance; handshake then returns IDLE.
REQ-038 in_ctl 1111 -> out_illegal 1, out_result 0, out_valid at N+1, alu_* unchanged.
REQ-039 rst_n pulsed low mid-EXEC -> all outputs 0 immediately, no out_valid after release, next request completes normally.
